// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM memory responder: response codes, FSM states
// and the waitrequest-stall LFSR seed and step function.
package avalon_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci step with taps 16,14,13,11 (bit 15 is tap 16).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM slave-side bus between the control unit (master) and the memory responder (slave).
interface avalon_mem_responder_if;

    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_address;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        slave_writeresponsevalid;
    logic [1:0]  slave_response;

    modport master (
        output slave_read, slave_write, slave_address, slave_writedata,
        input  slave_waitrequest, slave_readdata, slave_readdatavalid,
        input  slave_writeresponsevalid, slave_response
    );

    modport slave (
        input  slave_read, slave_write, slave_address, slave_writedata,
        output slave_waitrequest, slave_readdata, slave_readdatavalid,
        output slave_writeresponsevalid, slave_response
    );

endinterface

// File: rtl/avalon_mem_responder_resp_pipe.sv
// Fixed-depth in-order response shift register; the last stage drives the
// response strobes, code and read data directly from flops.
module resp_pipe
    import avalon_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        push_i,
    input  logic        push_write_i,
    input  logic        push_err_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rd_valid_o,
    output logic        wr_valid_o,
    output resp_e       resp_o,
    output logic [31:0] data_o
);

    logic [DEPTH-1:0] rdv_q, rdv_d;
    logic [DEPTH-1:0] wrv_q, wrv_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];

    // Shift one stage per cycle; RAM data for an in-range read is taken while the read sits in stage 1.
    always_comb begin
        rdv_d[0]  = push_i & ~push_write_i;
        wrv_d[0]  = push_i &  push_write_i;
        err_d[0]  = push_i &  push_err_i;
        data_d[0] = 32'h0000_0000;
        rdv_d[1]  = rdv_q[0];
        wrv_d[1]  = wrv_q[0];
        err_d[1]  = err_q[0];
        if (rdv_q[0] && !err_q[0]) begin
            data_d[1] = mem_rdata_i;
        end else begin
            data_d[1] = data_q[0];
        end
        for (int i = 2; i < DEPTH; i++) begin
            rdv_d[i]  = rdv_q[i-1];
            wrv_d[i]  = wrv_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdv_q <= {DEPTH{1'b0}};
            wrv_q <= {DEPTH{1'b0}};
            err_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) data_q[i] <= 32'h0000_0000;
        end else begin
            rdv_q <= rdv_d;
            wrv_q <= wrv_d;
            err_q <= err_d;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
        end
    end

    assign rd_valid_o = rdv_q[DEPTH-1];
    assign wr_valid_o = wrv_q[DEPTH-1];
    assign resp_o     = err_q[DEPTH-1] ? RESP_SLVERR : RESP_OKAY;
    assign data_o     = data_q[DEPTH-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: clears the RAM after reset, then serves single-word
// requests in order with fixed latency. Define RESPONDER_STALL_EN for random waitrequest.
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    avalon_mem_responder_if.slave bus,
    output logic                  protocol_err,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [3:0]    pending_q, pending_d;
    logic          wait_q, wait_d;
    logic          perr_q, perr_d;
    logic          stall_s;
    logic          accept_s;
    logic          in_range_s;
    logic          rd_valid_s;
    logic          wr_valid_s;
    resp_e         resp_s;
    logic [31:0]   rdata_s;

    assign in_range_s = (bus.slave_address < 32'(MEM_WORDS));
    assign accept_s   = (state_q == ST_READY) && (bus.slave_read ^ bus.slave_write) && !wait_q;

`ifdef RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR only runs once the responder is serving requests.
    always_comb begin
        if (state_q == ST_READY) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Stall LFSR register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_s = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // Next state and RAM port; INIT writes zero everywhere, gated so nothing is written while in reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_addr   = {AW{1'b0}};
        mem_we     = 1'b0;
        mem_wdata  = 32'h0000_0000;
        case (state_q)
            ST_INIT: begin
                mem_addr = init_cnt_q;
                mem_we   = n_rst;
                if (init_cnt_q == AW'(MEM_WORDS - 1)) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                if (accept_s && in_range_s) begin
                    mem_addr  = bus.slave_address[AW-1:0];
                    mem_we    = bus.slave_write;
                    mem_wdata = bus.slave_writedata;
                end else begin
                    mem_we = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Outstanding count and registered waitrequest; using the next count raises waitrequest right after the limit is hit.
    always_comb begin
        if (accept_s && !(rd_valid_s || wr_valid_s)) begin
            pending_d = pending_q + 4'd1;
        end else if (!accept_s && (rd_valid_s || wr_valid_s)) begin
            pending_d = pending_q - 4'd1;
        end else begin
            pending_d = pending_q;
        end
        wait_d = (state_q != ST_READY) || (pending_d == 4'(MAX_PENDING)) || stall_s;
        perr_d = perr_q || (bus.slave_read && bus.slave_write);
    end

    // Control registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= {AW{1'b0}};
            pending_q  <= 4'd0;
            wait_q     <= 1'b1;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            wait_q     <= wait_d;
            perr_q     <= perr_d;
        end
    end

    resp_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_resp_pipe (
        .clk          (clk),
        .n_rst        (n_rst),
        .push_i       (accept_s),
        .push_write_i (bus.slave_write),
        .push_err_i   (!in_range_s),
        .mem_rdata_i  (mem_rdata),
        .rd_valid_o   (rd_valid_s),
        .wr_valid_o   (wr_valid_s),
        .resp_o       (resp_s),
        .data_o       (rdata_s)
    );

    assign bus.slave_waitrequest        = wait_q;
    assign bus.slave_readdatavalid      = rd_valid_s;
    assign bus.slave_writeresponsevalid = wr_valid_s;
    assign bus.slave_response           = resp_s;
    assign bus.slave_readdata           = rdata_s;
    assign protocol_err                 = perr_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed plus random stimulus against a transaction-level model: a queue of
// expected responses with due cycles and a shadow copy of memory.
module tb_avalon_mem_responder;

    localparam int MEM_WORDS    = 16;
    localparam int READ_LATENCY = 6;
    localparam int MAX_PENDING  = 4;
    localparam int AW           = $clog2(MEM_WORDS);

    typedef struct {
        int          due;
        bit          is_wr;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          n_rst;
    logic          protocol_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   ram [MEM_WORDS];

    int          checks;
    int          errors;
    int          cyc;
    bit          perr_exp;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [MEM_WORDS];

    avalon_mem_responder_if bus_if ();

    avalon_mem_responder #(
        .MEM_WORDS    (MEM_WORDS),
        .READ_LATENCY (READ_LATENCY),
        .MAX_PENDING  (MAX_PENDING)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bus          (bus_if.slave),
        .protocol_err (protocol_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External synchronous single-port RAM: data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
        bus_if.slave_read      = rd;
        bus_if.slave_write     = wr;
        bus_if.slave_address   = addr;
        bus_if.slave_writedata = wdat;
    endtask

    // One clock cycle: check outputs of the current cycle, apply a request, advance the model.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
        bit          exp_wait;
        bit          acc;
        bit          inr;
        exp_t        got;
        exp_t        nxt;
        logic        exp_rdv;
        logic        exp_wrv;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        exp_wait = (cyc <= MEM_WORDS) || (exp_q.size() == MAX_PENDING);
        exp_rdv  = 1'b0;
        exp_wrv  = 1'b0;
        exp_resp = 2'b00;
        exp_data = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            got      = exp_q.pop_front();
            exp_rdv  = !got.is_wr;
            exp_wrv  = got.is_wr;
            exp_resp = got.err ? 2'b10 : 2'b00;
            exp_data = got.data;
        end
        chk("waitrequest", 32'(bus_if.slave_waitrequest), 32'(exp_wait));
        chk("readdatavalid", 32'(bus_if.slave_readdatavalid), 32'(exp_rdv));
        chk("writeresponsevalid", 32'(bus_if.slave_writeresponsevalid), 32'(exp_wrv));
        chk("response", 32'(bus_if.slave_response), 32'(exp_resp));
        chk("readdata", bus_if.slave_readdata, exp_data);
        chk("protocol_err", 32'(protocol_err), 32'(perr_exp));
        drive(rd, wr, addr, wdat);
        #1;
        acc = !exp_wait && (rd != wr);
        inr = (addr < 32'(MEM_WORDS));
        if (cyc < MEM_WORDS) begin
            chk("init_mem_we", 32'(mem_we), 32'd1);
            chk("init_mem_addr", 32'(mem_addr), 32'(cyc));
            chk("init_mem_wdata", mem_wdata, 32'h0);
        end else begin
            chk("mem_we", 32'(mem_we), 32'(acc && wr && inr));
        end
        if (acc && inr) begin
            chk("mem_addr", 32'(mem_addr), 32'(addr[AW-1:0]));
            if (wr) chk("mem_wdata", mem_wdata, wdat);
        end
        if (acc) begin
            nxt.due   = cyc + READ_LATENCY;
            nxt.is_wr = wr;
            nxt.err   = !inr;
            nxt.data  = (wr || !inr) ? 32'h0 : ref_mem[addr[AW-1:0]];
            if (wr && inr) ref_mem[addr[AW-1:0]] = wdat;
            exp_q.push_back(nxt);
        end
        if (rd && wr) perr_exp = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Hold reset for n cycles checking reset values, then release; the release cycle is cycle 0.
    task automatic reset_pulse(input int n);
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_waitrequest", 32'(bus_if.slave_waitrequest), 32'd1);
            chk("rst_readdatavalid", 32'(bus_if.slave_readdatavalid), 32'd0);
            chk("rst_writeresponsevalid", 32'(bus_if.slave_writeresponsevalid), 32'd0);
            chk("rst_readdata", bus_if.slave_readdata, 32'h0);
            chk("rst_response", 32'(bus_if.slave_response), 32'd0);
            chk("rst_protocol_err", 32'(protocol_err), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            @(posedge clk);
            #1;
        end
        n_rst = 1'b1;
        exp_q.delete();
        perr_exp = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
        cyc = 0;
    endtask

    task automatic random_traffic(input int n);
        int          op;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, MEM_WORDS + 3));
            step(op == 1, op == 2, a, $urandom);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        perr_exp = 1'b0;
        n_rst    = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        reset_pulse(3);

        // INIT sweep, with a read attempted while waitrequest is still high.
        idle(MEM_WORDS);
        step(1'b1, 1'b0, 32'd2, 32'h0);

        // Read of cleared memory.
        step(1'b1, 1'b0, 32'd5, 32'h0);
        idle(READ_LATENCY + 2);

        // Write then read the same word on the next cycle.
        step(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'd7, 32'h0);
        idle(READ_LATENCY + 2);

        // Reads every cycle: pending limit back-pressure.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'(i % MEM_WORDS), 32'h0);
        idle(READ_LATENCY + 2);

        // Out-of-range requests.
        step(1'b0, 1'b1, 32'(MEM_WORDS), 32'hA5A5_A5A5);
        step(1'b1, 1'b0, 32'(MEM_WORDS), 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        step(1'b1, 1'b0, 32'd0, 32'h0);
        idle(READ_LATENCY + 2);

        // Read and write together: nothing accepted, sticky error.
        step(1'b1, 1'b1, 32'd3, 32'h1234_5678);
        idle(READ_LATENCY + 2);

        random_traffic(300);
        idle(READ_LATENCY + 2);

        // Reset with two responses in flight, then INIT re-runs and the counter starts empty.
        step(1'b0, 1'b1, 32'd9, 32'hCAFE_F00D);
        step(1'b1, 1'b0, 32'd9, 32'h0);
        reset_pulse(2);
        idle(MEM_WORDS + 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd9, 32'h0);
        random_traffic(150);
        idle(READ_LATENCY + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_mem_responder.md
# avalon_mem_responder

Avalon-MM memory responder: the slave end of the read/write master interface the cartoonifier control unit drives toward image memory. Accepts single-word read/write requests, issues them to an external synchronous single-port RAM, and returns in-order `readdatavalid`/`writeresponsevalid` responses after a fixed latency, with `waitrequest` back-pressure. It stands in for SDRAM in block-level simulation and FPGA bring-up.

## Interface
- `MEM_WORDS`, 4096: addressable words; word address = `slave_address` value.
- `READ_LATENCY`, 2: cycles from accept to response; legal range 2..15.
- `MAX_PENDING`, 4: maximum accepted-but-unresponded requests; 1..15.
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `slave_read` in 1: read request.
- `slave_write` in 1: write request.
- `slave_address` in 32: word address.
- `slave_writedata` in 32: write data.
- `slave_waitrequest` out 1: request not accepted this cycle.
- `slave_readdata` out 32: read data, valid with `slave_readdatavalid`.
- `slave_readdatavalid` out 1: read response strobe.
- `slave_writeresponsevalid` out 1: write response strobe.
- `slave_response` out 2: `00` OKAY, `10` SLVERR; valid with either strobe.
- `protocol_err` out 1: sticky; set when read and write asserted together.
- `mem_addr` out clog2(MEM_WORDS): RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_addr` is presented.

## Operation
- FSM states: INIT, READY.
- INIT (entered on reset): clear counter 0..MEM_WORDS-1 drives `mem_addr`, `mem_we`=1, `mem_wdata`=0; `slave_waitrequest`=1. Transition to READY the cycle after the counter reaches MEM_WORDS-1.
- READY: accept = (`slave_read` XOR `slave_write`) && !`slave_waitrequest`.
- `slave_waitrequest` = (state≠READY) || (pending==MAX_PENDING) || stall; no combinational path from slave inputs.
- Read and write together: neither accepted, `protocol_err` set until reset.
- In range (address < MEM_WORDS): accepted request drives `mem_addr`/`mem_we`/`mem_wdata` same cycle. Out of range: no RAM access, response SLVERR, `slave_readdata`=0.
- Response pipeline: READ_LATENCY-stage shift register of {valid, is_write, err, data}; RAM data captured into stage 1; one response per cycle, strictly in accept order, write and read responses interleaved in the same pipeline.
- Pending counter (4 bits): +1 on accept, -1 on response strobe, unchanged when both.
- Responses cannot be back-pressured.

## Timing
- Reset values: `slave_waitrequest`=1, `slave_readdatavalid`=0, `slave_writeresponsevalid`=0, `slave_readdata`=0, `slave_response`=00, `protocol_err`=0, `mem_we`=0 during reset then 1 in INIT, pending=0, pipeline invalid.
- Accept in cycle T → response strobe high for exactly one cycle in cycle T+READ_LATENCY; all slave outputs registered.
- Write data is in RAM at the end of cycle T; a read accepted at T+1 to the same address returns the new data.
- Back-to-back accepts every cycle while pending < MAX_PENDING.
- Pending reaching MAX_PENDING: `slave_waitrequest` high from the next cycle, even if a response retires that cycle; drops the cycle after pending < MAX_PENDING.
- Reset mid-operation: in-flight responses discarded, no strobes emitted, INIT restarts from address 0.

## Configuration
- `RESPONDER_STALL_EN` defined: 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle in READY; stall = LFSR[1:0]==2'b00 (~25 % injected `waitrequest`). Undefined: stall tied 0; `waitrequest` only from INIT and pending limit.

## Structure
- Shared package `avalon_pkg`: response enum (OKAY=2'b00, SLVERR=2'b10), FSM state typedef, LFSR seed constant.
- One sub-module `resp_pipe`: parameterised-depth response shift register producing the strobes, response code and data.

## Test plan
- Reset release, MEM_WORDS=16 → `slave_waitrequest` high 16 cycles plus 1, then low; read address 5 → `slave_readdata`=0, OKAY, at T+2.
- Write 0xDEADBEEF to 7 at T, read 7 at T+1 → `writeresponsevalid` at T+2, `readdatavalid` at T+3 with 0xDEADBEEF.
- READ_LATENCY=6, MAX_PENDING=4, reads every cycle → 4 accepted, `waitrequest` high until first response at T+6, responses in order.
- Write address 4096 (MEM_WORDS=4096) → `mem_we` not asserted for it, SLVERR at T+2; read 4096 → data 0, SLVERR.
- `slave_read`=`slave_write`=1 → no accept, no response, `protocol_err`=1 until reset.
- `n_rst` pulsed with 2 responses in flight → no strobes afterward, INIT re-runs, pending=0.
